// File: rtl/fifo_sync_multi_ch.sv
// N-channel single-clock FIFO: independent per-channel pointers, occupancy count,
// threshold flags, flush, error pulses and optional first-word-fall-through read.
module fifo_sync_multi_ch #(
  parameter int NUM_CH            = 2,
  parameter int DATA_WIDTH        = 18,
  parameter int DEPTH             = 1024,
  parameter int PROG_EMPTY_THRESH = 4,
  parameter int PROG_FULL_THRESH  = 1018,
  parameter int FWFT              = 0
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic [NUM_CH-1:0]                         FLUSH,
  input  logic [NUM_CH-1:0]                         WR_EN,
  input  logic [NUM_CH*DATA_WIDTH-1:0]              WR_DATA,
  input  logic [NUM_CH-1:0]                         RD_EN,
  output logic [NUM_CH*DATA_WIDTH-1:0]              RD_DATA,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]       COUNT,
  output logic [NUM_CH-1:0]                         EMPTY,
  output logic [NUM_CH-1:0]                         ALMOST_EMPTY,
  output logic [NUM_CH-1:0]                         PROG_EMPTY,
  output logic [NUM_CH-1:0]                         FULL,
  output logic [NUM_CH-1:0]                         ALMOST_FULL,
  output logic [NUM_CH-1:0]                         PROG_FULL,
  output logic [NUM_CH-1:0]                         OVERFLOW,
  output logic [NUM_CH-1:0]                         UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (NUM_CH < 1 || NUM_CH > 8 || DATA_WIDTH < 1 || DATA_WIDTH > 72 ||
      DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 2 ||
      PROG_FULL_THRESH < 2 || PROG_FULL_THRESH > DEPTH - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_param_err
    $error("%m: fifo_sync_multi_ch parameter out of range");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] mem_rd_word;
    logic                  is_empty, is_full, wr_acc, rd_acc;

    assign wr_word     = WR_DATA[c*DATA_WIDTH +: DATA_WIDTH];
    assign mem_rd_word = mem_q[rd_ptr_q];
    assign is_empty    = (count_q == '0);
    assign is_full     = (count_q == CW'(DEPTH));
    // Acceptance looks only at the pre-edge count, so a same-cycle read never frees a full FIFO.
    assign wr_acc      = WR_EN[c] && !is_full && !FLUSH[c];
    assign rd_acc      = RD_EN[c] && !is_empty && !FLUSH[c];

    always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      if (FLUSH[c]) begin
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        count_d   = '0;
        rd_data_d = '0;
      end else begin
        ovf_d = WR_EN[c] && is_full;
        unf_d = RD_EN[c] && is_empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_data_d = mem_rd_word;
        end
        case ({wr_acc, rd_acc})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        rd_data_q <= '0;
        ovf_q     <= 1'b0;
        unf_q     <= 1'b0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        count_q   <= count_d;
        rd_data_q <= rd_data_d;
        ovf_q     <= ovf_d;
        unf_q     <= unf_d;
      end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
      if (RESET && wr_acc) mem_q[wr_ptr_q] <= wr_word;
    end

    assign RD_DATA[c*DATA_WIDTH +: DATA_WIDTH] = (FWFT != 0) ? (is_empty ? '0 : mem_rd_word)
                                                             : rd_data_q;
    assign COUNT[c*CW +: CW] = count_q;
    assign EMPTY[c]          = is_empty;
    assign ALMOST_EMPTY[c]   = (count_q == CW'(1));
    assign PROG_EMPTY[c]     = (count_q <= CW'(PROG_EMPTY_THRESH));
    assign FULL[c]           = is_full;
    assign ALMOST_FULL[c]    = (count_q == CW'(DEPTH - 1));
    assign PROG_FULL[c]      = (count_q >= CW'(PROG_FULL_THRESH));
    assign OVERFLOW[c]       = ovf_q;
    assign UNDERFLOW[c]      = unf_q;
  end

endmodule

// File: tb/tb_fifo_sync_multi_ch.sv
// Bench for fifo_sync_multi_ch: a standard-read and an FWFT instance share stimulus and are
// compared against per-channel queues, a constant vector table and directed corner sequences.
module tb_fifo_sync_multi_ch;
  localparam int NCH = 2;
  localparam int DW  = 18;
  localparam int DEP = 16;
  localparam int PET = 4;
  localparam int PFT = 12;
  localparam int CW  = $clog2(DEP) + 1;

  typedef logic [DW-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic [NCH-1:0]    flush = '0, wr_en = '0, rd_en = '0;
  logic [NCH*DW-1:0] wr_data = '0;

  logic [NCH*DW-1:0] rd_a, rd_b;
  logic [NCH*CW-1:0] cnt_a, cnt_b;
  logic [NCH-1:0]    e_a, ae_a, pe_a, f_a, af_a, pf_a, ovf_a, unf_a;
  logic [NCH-1:0]    e_b, ae_b, pe_b, f_b, af_b, pf_b, ovf_b, unf_b;

  fifo_sync_multi_ch #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .PROG_EMPTY_THRESH(PET),
                       .PROG_FULL_THRESH(PFT), .FWFT(0)) u_std (
    .CLK(clk), .RESET(rst_b), .FLUSH(flush), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rd_a), .COUNT(cnt_a), .EMPTY(e_a), .ALMOST_EMPTY(ae_a), .PROG_EMPTY(pe_a),
    .FULL(f_a), .ALMOST_FULL(af_a), .PROG_FULL(pf_a), .OVERFLOW(ovf_a), .UNDERFLOW(unf_a));

  fifo_sync_multi_ch #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP), .PROG_EMPTY_THRESH(PET),
                       .PROG_FULL_THRESH(PFT), .FWFT(1)) u_fwft (
    .CLK(clk), .RESET(rst_b), .FLUSH(flush), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rd_b), .COUNT(cnt_b), .EMPTY(e_b), .ALMOST_EMPTY(ae_b), .PROG_EMPTY(pe_b),
    .FULL(f_b), .ALMOST_FULL(af_b), .PROG_FULL(pf_b), .OVERFLOW(ovf_b), .UNDERFLOW(unf_b));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one queue per channel plus the last word read out.
  word_t mq [NCH][$];
  word_t m_rd [NCH];
  bit    m_ovf [NCH];
  bit    m_unf [NCH];

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NCH; c++) begin
      if (!rst_b || flush[c]) begin
        mq[c].delete();
        m_rd[c]  = '0;
        m_ovf[c] = 1'b0;
        m_unf[c] = 1'b0;
      end else begin
        bit full, empty;
        full     = (mq[c].size() == DEP);
        empty    = (mq[c].size() == 0);
        m_ovf[c] = wr_en[c] && full;
        m_unf[c] = rd_en[c] && empty;
        if (rd_en[c] && !empty) m_rd[c] = mq[c].pop_front();
        if (wr_en[c] && !full) mq[c].push_back(wr_data[c*DW +: DW]);
      end
    end
  endtask

  task automatic check_model();
    for (int c = 0; c < NCH; c++) begin
      int n;
      logic [5:0] exp_fl;
      n = mq[c].size();
      exp_fl = {n == DEP, n == DEP - 1, n >= PFT, n == 0, n == 1, n <= PET};
      chk("count_std", c, 64'(cnt_a[c*CW +: CW]), 64'(n));
      chk("count_fwft", c, 64'(cnt_b[c*CW +: CW]), 64'(n));
      chk("flags_std", c, 64'({f_a[c], af_a[c], pf_a[c], e_a[c], ae_a[c], pe_a[c]}), 64'(exp_fl));
      chk("flags_fwft", c, 64'({f_b[c], af_b[c], pf_b[c], e_b[c], ae_b[c], pe_b[c]}), 64'(exp_fl));
      chk("err_std", c, 64'({ovf_a[c], unf_a[c]}), 64'({m_ovf[c], m_unf[c]}));
      chk("err_fwft", c, 64'({ovf_b[c], unf_b[c]}), 64'({m_ovf[c], m_unf[c]}));
      chk("rd_std", c, 64'(rd_a[c*DW +: DW]), 64'(m_rd[c]));
      chk("rd_fwft", c, 64'(rd_b[c*DW +: DW]), (n > 0) ? 64'(mq[c][0]) : 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic drive(input logic [1:0] fl, input logic [1:0] we, input logic [1:0] re,
                       input word_t d0, input word_t d1);
    flush   = fl;
    wr_en   = we;
    rd_en   = re;
    wr_data = {d1, d0};
  endtask

  typedef struct {
    bit         rst_b;
    logic [1:0] flush;
    logic [1:0] wr;
    logic [1:0] rd;
    word_t      wd0;
    logic [4:0] cnt0;
    logic [5:0] fl0;    // {full, almost_full, prog_full, empty, almost_empty, prog_empty}
    word_t      rd0;
    logic [1:0] err0;   // {overflow, underflow}
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 2'b00, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b00};
    tbl[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b00};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b00};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b00};
    tbl[4]  = '{1'b1, 2'b00, 2'b00, 2'b01, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b01};
    tbl[5]  = '{1'b1, 2'b00, 2'b00, 2'b00, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b00};
    tbl[6]  = '{1'b1, 2'b00, 2'b01, 2'b00, 18'h00011, 5'd1, 6'b000011, 18'h00000, 2'b00};
    tbl[7]  = '{1'b1, 2'b00, 2'b01, 2'b00, 18'h00022, 5'd2, 6'b000001, 18'h00000, 2'b00};
    tbl[8]  = '{1'b1, 2'b00, 2'b01, 2'b01, 18'h00033, 5'd2, 6'b000001, 18'h00011, 2'b00};
    tbl[9]  = '{1'b1, 2'b00, 2'b00, 2'b01, 18'h00000, 5'd1, 6'b000011, 18'h00022, 2'b00};
    tbl[10] = '{1'b1, 2'b00, 2'b00, 2'b01, 18'h00000, 5'd0, 6'b000101, 18'h00033, 2'b00};
    tbl[11] = '{1'b1, 2'b00, 2'b00, 2'b01, 18'h00000, 5'd0, 6'b000101, 18'h00033, 2'b01};
    tbl[12] = '{1'b1, 2'b01, 2'b01, 2'b00, 18'h00044, 5'd0, 6'b000101, 18'h00000, 2'b00};
    tbl[13] = '{1'b1, 2'b00, 2'b01, 2'b01, 18'h00055, 5'd1, 6'b000011, 18'h00000, 2'b01};
    tbl[14] = '{1'b0, 2'b00, 2'b00, 2'b00, 18'h00000, 5'd0, 6'b000101, 18'h00000, 2'b00};

    for (int i = 0; i < 15; i++) begin
      rst_b = tbl[i].rst_b;
      drive(tbl[i].flush, tbl[i].wr, tbl[i].rd, tbl[i].wd0, '0);
      step();
      chk("tbl_count", 0, 64'(cnt_a[CW-1:0]), 64'(tbl[i].cnt0));
      chk("tbl_flags", 0, 64'({f_a[0], af_a[0], pf_a[0], e_a[0], ae_a[0], pe_a[0]}), 64'(tbl[i].fl0));
      chk("tbl_rd", 0, 64'(rd_a[DW-1:0]), 64'(tbl[i].rd0));
      chk("tbl_err", 0, 64'({ovf_a[0], unf_a[0]}), 64'(tbl[i].err0));
    end
    rst_b = 1'b1;

    // Fill and drain channel 0 with 1..16.
    for (int k = 1; k <= DEP; k++) begin
      drive(2'b00, 2'b01, 2'b00, word_t'(k), '0);
      step();
      if (k == PET + 1) chk("pe_clear_at5", 0, 64'(pe_a[0]), 64'd0);
      if (k == PFT) chk("pf_set_at12", 0, 64'(pf_a[0]), 64'd1);
    end
    chk("fill_full", 0, 64'(f_a[0]), 64'd1);
    for (int k = 1; k <= DEP; k++) begin
      drive(2'b00, 2'b00, 2'b01, '0, '0);
      step();
      chk("drain_data", 0, 64'(rd_a[DW-1:0]), 64'(k));
    end
    chk("drain_empty", 0, 64'(e_a[0]), 64'd1);

    // Overflow with a marker word that must never surface, then underflow.
    for (int k = 0; k < DEP; k++) begin
      drive(2'b00, 2'b01, 2'b00, word_t'(18'h100 + k), '0);
      step();
    end
    drive(2'b00, 2'b01, 2'b00, 18'h3FFFF, '0);
    step();
    chk("ovf_pulse", 0, 64'(ovf_a[0]), 64'd1);
    chk("ovf_count", 0, 64'(cnt_a[CW-1:0]), 64'd16);
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    step();
    chk("ovf_one_cycle", 0, 64'(ovf_a[0]), 64'd0);
    for (int k = 0; k < DEP; k++) begin
      drive(2'b00, 2'b00, 2'b01, '0, '0);
      step();
      chk("no_marker", 0, 64'(rd_a[DW-1:0] == 18'h3FFFF), 64'd0);
    end
    step();
    chk("unf_pulse", 0, 64'(unf_a[0]), 64'd1);
    chk("unf_rd_hold", 0, 64'(rd_a[DW-1:0]), 64'h10F);
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    step();

    // Simultaneous read/write at count 8 across the pointer wrap, then at full.
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 2'b01, 2'b00, word_t'(18'h200 + k), '0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(2'b00, 2'b01, 2'b01, word_t'(18'h300 + k), '0);
      step();
      chk("rw_count8", 0, 64'(cnt_a[CW-1:0]), 64'd8);
    end
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 2'b01, 2'b00, word_t'(18'h400 + k), '0);
      step();
    end
    drive(2'b00, 2'b01, 2'b01, 18'h2AAAA, '0);
    step();
    chk("full_rw_count", 0, 64'(cnt_a[CW-1:0]), 64'd15);
    chk("full_rw_ovf", 0, 64'(ovf_a[0]), 64'd1);

    // FWFT: a single word shows up without a read, and disappears on read.
    drive(2'b11, 2'b00, 2'b00, '0, '0);
    step();
    drive(2'b00, 2'b01, 2'b00, 18'h0ABCD, '0);
    step();
    chk("fwft_not_empty", 0, 64'(e_b[0]), 64'd0);
    chk("fwft_data", 0, 64'(rd_b[DW-1:0]), 64'h0ABCD);
    drive(2'b00, 2'b00, 2'b01, '0, '0);
    step();
    chk("fwft_empty", 0, 64'(e_b[0]), 64'd1);
    chk("fwft_zero", 0, 64'(rd_b[DW-1:0]), 64'd0);

    // Flush isolation: channel 0 to 10, channel 1 to 6, flush channel 0 alone.
    for (int k = 0; k < 10; k++) begin
      drive(2'b00, {k < 6, 1'b1}, 2'b00, word_t'(18'h500 + k), word_t'(18'h600 + k));
      step();
    end
    drive(2'b01, 2'b01, 2'b00, 18'h3FFFF, '0);
    step();
    chk("flush_count0", 0, 64'(cnt_a[CW-1:0]), 64'd0);
    chk("flush_empty0", 0, 64'(e_a[0]), 64'd1);
    chk("flush_no_ovf", 0, 64'(ovf_a[0]), 64'd0);
    chk("flush_count1", 1, 64'(cnt_a[2*CW-1:CW]), 64'd6);
    for (int k = 0; k < 6; k++) begin
      drive(2'b00, 2'b00, 2'b10, '0, '0);
      step();
      chk("ch1_intact", 1, 64'(rd_a[2*DW-1:DW]), 64'(18'h600 + k));
    end

    // Randomised traffic in phases of varying write/read bias.
    for (int ph = 0; ph < 12; ph++) begin
      int unsigned pwr, prd;
      pwr = $urandom_range(90, 10);
      prd = 100 - pwr;
      for (int k = 0; k < 150; k++) begin
        rst_b = ($urandom_range(299) != 0);
        for (int c = 0; c < NCH; c++) begin
          flush[c] = ($urandom_range(63) == 0);
          wr_en[c] = ($urandom_range(99) < pwr);
          rd_en[c] = ($urandom_range(99) < prd);
        end
        wr_data = {18'($urandom), 18'($urandom)};
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
